sgd_work_send: RTL and testbench

Worker-side transmit stage for the distributed SGD pipeline. Collects the per-bank 32-bit `ax_minus_b_sign_shifted_result` values produced by the local dot-product banks. Once all `NUM_OF_BANKS` (8) values of one sample are present, it packs them into a single 256-bit payload and sends it as one network message. The downstream peer's receive stage unpacks that message back into per-bank results. A small FIFO decouples bank completion from network back-pressure.

---
 rtl/sgd_work_send_if.sv | 26 ++
 rtl/sgd_work_send.sv | 172 +++++++++++++++++
 tb/tb_sgd_work_send.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgd_work_send_if.sv
// Stream interfaces used by the SGD worker transmit stage: a metadata
// channel (session/length descriptor) and a data channel (payload beats).

interface axis_meta #(
  parameter int DATA_W = 48
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

interface axi_stream #(
  parameter int DATA_W = 512
);
  logic                valid;
  logic                ready;
  logic [DATA_W-1:0]   data;
  logic [DATA_W/8-1:0] keep;
  logic                last;

  modport master (output valid, output data, output keep, output last, input ready);
  modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/sgd_work_send.sv
// Worker-side transmit stage: gathers one 32-bit result per bank, packs a
// complete sample into a 256-bit payload, buffers it in a small FIFO and
// sends it as a metadata beat followed by a single data beat.

module sgd_work_send #(
  parameter int NUM_OF_BANKS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              session_id,
  input  logic signed [31:0]       ax_minus_b_sign_shifted_result [NUM_OF_BANKS-1:0],
  input  logic [NUM_OF_BANKS-1:0]  ax_minus_b_sign_shifted_result_valid,
  axis_meta.master                 m_axis_tx_metadata,
  axi_stream.master                m_axis_tx_data,
  output logic [31:0]              drop_cnt,
  output logic [31:0]              sent_cnt,
  output logic                     dup_err
);

  localparam int PAY_W = NUM_OF_BANKS * 32;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [15:0] MSG_BYTES = 16'(NUM_OF_BANKS * 4);

  typedef enum logic [1:0] {IDLE, META, DATA} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [NUM_OF_BANKS-1:0] got;
  logic [PAY_W-1:0]        staging;
  logic [PAY_W-1:0]        merged;
  logic                    complete;
  logic                    dup_hit;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic [PAY_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W:0]          count;
  logic [15:0]             sess_q;

  // Merge this cycle's strobed lanes over the staged lanes
  always_comb begin
    merged = staging;
    for (int i = 0; i < NUM_OF_BANKS; i++) begin
      if (ax_minus_b_sign_shifted_result_valid[i]) begin
        merged[i*32 +: 32] = ax_minus_b_sign_shifted_result[i];
      end
    end
  end

  assign complete = &(got | ax_minus_b_sign_shifted_result_valid);
  assign dup_hit  = (|(got & ax_minus_b_sign_shifted_result_valid)) && !complete;
  assign full     = (count == FULL_CNT);
  assign push     = complete && !full;
  assign pop      = (state == DATA) && m_axis_tx_data.ready;

  // Staging word follows the merged lanes; only got qualifies it
  always_ff @(posedge clk) begin
    staging <= merged;
  end

  // Track which banks have delivered for the sample being collected
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      got <= '0;
    end else if (complete) begin
      got <= '0;
    end else begin
      got <= got | ax_minus_b_sign_shifted_result_valid;
    end
  end

  // Sticky flag for a bank strobing twice within one collection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dup_err <= 1'b0;
    end else if (dup_hit) begin
      dup_err <= 1'b1;
    end
  end

  // Count vectors lost because the FIFO was full at completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (complete && full) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end

  // Count messages whose data beat handshook
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sent_cnt <= '0;
    end else if (pop) begin
      sent_cnt <= sent_cnt + 32'd1;
    end
  end

  // FIFO storage; payload words are not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= merged;
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Capture the session when a message is about to be issued so it holds while stalled
  always_ff @(posedge clk) begin
    if ((state == IDLE) && (count != '0)) begin
      sess_q <= session_id;
    end
  end

  // Transmit FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Transmit FSM next state and channel outputs
  always_comb begin
    state_next               = state;
    m_axis_tx_metadata.valid = 1'b0;
    m_axis_tx_metadata.data  = '0;
    m_axis_tx_data.valid     = 1'b0;
    m_axis_tx_data.data      = '0;
    m_axis_tx_data.keep      = '0;
    m_axis_tx_data.last      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_next = META;
      end
      META: begin
        m_axis_tx_metadata.valid      = 1'b1;
        m_axis_tx_metadata.data[31:0] = {MSG_BYTES, sess_q};
        if (m_axis_tx_metadata.ready) state_next = DATA;
      end
      DATA: begin
        m_axis_tx_data.valid                 = 1'b1;
        m_axis_tx_data.data[PAY_W-1:0]       = mem[rd_ptr];
        m_axis_tx_data.keep[PAY_W/8-1:0]     = '1;
        m_axis_tx_data.last                  = 1'b1;
        if (m_axis_tx_data.ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sgd_work_send.sv
// Bench for sgd_work_send: a queue-based model of collected/sent vectors is
// checked every cycle, plus directed literal checks per scenario.

module tb_sgd_work_send;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [15:0]        session_id;
  logic signed [31:0] res [7:0];
  logic [7:0]         vld;
  logic [31:0]        drop_cnt;
  logic [31:0]        sent_cnt;
  logic               dup_err;

  axis_meta  #(.DATA_W(48))  meta_if ();
  axi_stream #(.DATA_W(512)) data_if ();

  always #5 clk = ~clk;

  sgd_work_send #(.NUM_OF_BANKS(8), .FIFO_DEPTH(4)) dut (
    .clk                                  (clk),
    .rst_n                                (rst_n),
    .session_id                           (session_id),
    .ax_minus_b_sign_shifted_result       (res),
    .ax_minus_b_sign_shifted_result_valid (vld),
    .m_axis_tx_metadata                   (meta_if),
    .m_axis_tx_data                       (data_if),
    .drop_cnt                             (drop_cnt),
    .sent_cnt                             (sent_cnt),
    .dup_err                              (dup_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit on_data, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(on_data ? data_if.valid : meta_if.valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, on_data ? data_if.valid : meta_if.valid, 1'b1);
  endtask

  // Model: lanes and presence bits of the open sample, queue of packed vectors
  logic [31:0]  m_lane [8];
  logic [7:0]   m_got;
  logic [255:0] m_q [$];
  int           m_drop;
  int           m_sent;
  bit           m_dup;
  bit           prev_meta_stall;
  bit           prev_data_stall;
  logic [47:0]  prev_meta;
  logic [511:0] prev_data;
  logic [63:0]  prev_keep;
  logic         prev_last;

  always @(negedge clk) begin
    bit           full;
    bit           done;
    logic [255:0] word;
    if (!rst_n) begin
      m_got = '0;
      m_q.delete();
      m_drop = 0;
      m_sent = 0;
      m_dup = 1'b0;
      prev_meta_stall = 1'b0;
      prev_data_stall = 1'b0;
    end else begin
      chk("both_valid", {255'd0, meta_if.valid & data_if.valid}, '0);
      if (prev_meta_stall) begin
        chk("meta_hold_valid", meta_if.valid, 1'b1);
        chk("meta_hold_data", meta_if.data, prev_meta);
      end
      if (prev_data_stall) begin
        chk("data_hold_valid", data_if.valid, 1'b1);
        chk("data_hold_lo", data_if.data[255:0], prev_data[255:0]);
        chk("data_hold_hi", data_if.data[511:256], prev_data[511:256]);
        chk("data_hold_keep", data_if.keep, prev_keep);
        chk("data_hold_last", data_if.last, prev_last);
      end
      if (meta_if.valid) chk("meta_data", meta_if.data, {16'd0, 16'd32, session_id});
      if (data_if.valid) begin
        if (m_q.size() == 0) chk("data_unexpected", data_if.valid, 1'b0);
        else chk("data_payload", data_if.data[255:0], m_q[0]);
        chk("data_upper", data_if.data[511:256], '0);
        chk("data_keep", data_if.keep, 64'h0000_0000_FFFF_FFFF);
        chk("data_last", data_if.last, 1'b1);
      end
      chk("drop_cnt", drop_cnt, 32'(m_drop));
      chk("sent_cnt", sent_cnt, 32'(m_sent));
      chk("dup_err", dup_err, m_dup);

      prev_meta_stall = meta_if.valid && !meta_if.ready;
      prev_data_stall = data_if.valid && !data_if.ready;
      prev_meta = meta_if.data;
      prev_data = data_if.data;
      prev_keep = data_if.keep;
      prev_last = data_if.last;

      full = (m_q.size() >= 4);
      if (data_if.valid && data_if.ready && m_q.size() > 0) begin
        void'(m_q.pop_front());
        m_sent++;
      end
      done = ((m_got | vld) == 8'hFF);
      if (!done && ((m_got & vld) != 8'h00)) m_dup = 1'b1;
      for (int i = 0; i < 8; i++) if (vld[i]) m_lane[i] = res[i];
      if (done) begin
        for (int i = 0; i < 8; i++) word[i*32 +: 32] = m_lane[i];
        if (!full) m_q.push_back(word);
        else m_drop++;
        m_got = '0;
      end else begin
        m_got = m_got | vld;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    session_id = 16'hABCD;
    vld = '0;
    for (int i = 0; i < 8; i++) res[i] = '0;
    meta_if.ready = 1'b1;
    data_if.ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_meta_valid", meta_if.valid, 1'b0);
    chk("rst_data_valid", data_if.valid, 1'b0);
    chk("rst_meta_data", meta_if.data, '0);
    chk("rst_data", data_if.data[255:0], '0);
    chk("rst_keep", data_if.keep, '0);
    chk("rst_last", data_if.last, 1'b0);
    chk("rst_drop", drop_cnt, '0);
    chk("rst_sent", sent_cnt, '0);
    chk("rst_dup", dup_err, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // All banks in one cycle
    vld = 8'hFF;
    for (int i = 0; i < 8; i++) res[i] = 32'h1000_0000 + i;
    step();
    vld = '0;
    step();
    @(negedge clk);
    chk("t1_meta_valid", meta_if.valid, 1'b1);
    chk("t1_meta_data", meta_if.data[31:0], 32'h0020_ABCD);
    step();
    @(negedge clk);
    chk("t1_data_valid", data_if.valid, 1'b1);
    for (int i = 0; i < 8; i++) chk("t1_lane", data_if.data[i*32 +: 32], 32'h1000_0000 + i);
    chk("t1_keep", data_if.keep, 64'hFFFF_FFFF);
    chk("t1_last", data_if.last, 1'b1);
    step();
    @(negedge clk);
    chk("t1_sent", sent_cnt, 32'd1);
    step();

    // Banks one per cycle, 7 down to 0
    for (int b = 7; b >= 0; b--) begin
      vld = 8'h01 << b;
      res[b] = 32'h2000_0000 + b * 16;
      step();
      vld = '0;
      if (b > 0) begin
        @(negedge clk);
        chk("t2_no_early_meta", meta_if.valid, 1'b0);
      end
    end
    wait_valid(1'b1, "t2_data_valid");
    for (int i = 0; i < 8; i++) chk("t2_lane", data_if.data[i*32 +: 32], 32'h2000_0000 + i * 16);
    chk("t2_dup", dup_err, 1'b0);
    step();

    // Bank 3 strobed twice before completion
    vld = 8'h08;
    res[3] = 32'h0000_AAAA;
    step();
    res[3] = 32'h0000_BBBB;
    step();
    vld = 8'hF7;
    for (int i = 0; i < 8; i++) if (i != 3) res[i] = 32'h3000_0000 + i;
    step();
    vld = '0;
    @(negedge clk);
    chk("t3_dup", dup_err, 1'b1);
    wait_valid(1'b1, "t3_data_valid");
    chk("t3_lane3", data_if.data[127:96], 32'h0000_BBBB);
    chk("t3_lane0", data_if.data[31:0], 32'h3000_0000);
    step();
    step();

    // Reset between scenarios, then overflow with metadata stalled
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    meta_if.ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vld = 8'hFF;
      for (int i = 0; i < 8; i++) res[i] = 32'h4000_0000 + k * 256 + i;
      step();
    end
    vld = '0;
    step();
    @(negedge clk);
    chk("t4_drop", drop_cnt, 32'd2);
    chk("t4_sent0", sent_cnt, 32'd0);
    chk("t4_meta_stalled", meta_if.valid, 1'b1);
    step();
    meta_if.ready = 1'b1;
    wait_valid(1'b1, "t4_first_data");
    chk("t4_first_lane0", data_if.data[31:0], 32'h4000_0000);
    begin
      int n;
      n = 0;
      while (sent_cnt != 32'd4 && n < 60) begin
        step();
        @(negedge clk);
        n++;
      end
    end
    chk("t4_sent", sent_cnt, 32'd4);
    step();
    step();
    @(negedge clk);
    chk("t4_idle_meta", meta_if.valid, 1'b0);
    chk("t4_idle_data", data_if.valid, 1'b0);

    // data.ready toggling while data is offered
    data_if.ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vld = 8'hFF;
      for (int i = 0; i < 8; i++) res[i] = 32'h5000_0000 + k * 256 + i;
      step();
    end
    vld = '0;
    for (int n = 0; n < 40; n++) begin
      data_if.ready = ~data_if.ready;
      step();
    end
    data_if.ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("t5_sent", sent_cnt, 32'd6);

    // Reset while in DATA with vectors queued and a partial vector open
    data_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld = 8'hFF;
      for (int i = 0; i < 8; i++) res[i] = 32'h6000_0000 + k * 256 + i;
      step();
    end
    vld = 8'h7F;
    step();
    vld = '0;
    wait_valid(1'b1, "t6_in_data");
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_meta_valid", meta_if.valid, 1'b0);
    chk("t6_data_valid", data_if.valid, 1'b0);
    chk("t6_sent", sent_cnt, '0);
    chk("t6_drop", drop_cnt, '0);
    chk("t6_dup", dup_err, 1'b0);
    data_if.ready = 1'b1;
    step();
    vld = 8'h80;
    res[7] = 32'h0000_0001;
    step();
    vld = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("t6_quiet_meta", meta_if.valid, 1'b0);
      chk("t6_quiet_data", data_if.valid, 1'b0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
